morse_message_player: RTL and testbench

Sequencer for the board's Morse flasher. It queues up to DEPTH letter codes from a requester and plays them back-to-back on one LED. Each letter uses a fixed 14-unit pattern followed by an inter-letter gap. It replaces manual per-letter KEY presses with a FIFO, a unit-tick generator and a playback state machine.

---
 rtl/morse_message_player.sv | 181 ++++++++++++++++++
 tb/tb_morse_message_player.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_message_player.sv
`default_nettype none
// ============================================================================
// Module   : morse_message_player
// Purpose  : Queues 3-bit letter codes (S..Z) and plays each as a 14-unit
//            Morse pattern plus an inter-letter gap on one LED.
//            Build option MORSE_WORD_GAP_EN stretches the final gap to a word space.
// Revision : 1.0
// ============================================================================
module morse_message_player #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DEPTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   letter_valid,
    input  logic [2:0]             letter,
    output logic                   letter_ready,
    input  logic                   start,
    input  logic                   abort,
    output logic                   led,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_RELOAD     = TW'(TICK_DIV - 1);
    localparam logic [AW:0]   FULL_LEVEL      = (AW + 1)'(DEPTH);
    localparam logic [4:0]    LAST_SHIFT_UNIT = 5'd13;
    localparam logic [4:0]    LETTER_GAP_UNIT = 5'd15;
`ifdef MORSE_WORD_GAP_EN
    localparam logic [4:0]    WORD_GAP_UNIT   = 5'd19;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_next;
    logic [13:0]     pattern;
    logic [4:0]      unit_cnt;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            push;
    logic            pop;

    function automatic logic [13:0] pattern_of(input logic [2:0] code);
        case (code)
            3'd0:    return 14'b10101000000000;
            3'd1:    return 14'b11100000000000;
            3'd2:    return 14'b10101110000000;
            3'd3:    return 14'b10101011100000;
            3'd4:    return 14'b10111011100000;
            3'd5:    return 14'b11101010111000;
            3'd6:    return 14'b11101011101110;
            default: return 14'b11101110101000;
        endcase
    endfunction

    always_comb begin
        push       = letter_valid && letter_ready && !abort;
        pop        = (state == LOAD) && !abort;
        tick       = (tick_cnt == '0) && (state == SHIFT || state == GAP);
        level_next = level;
        if (push && !pop)
            level_next = level + (AW + 1)'(1);
        else if (pop && !push)
            level_next = level - (AW + 1)'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= letter;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            letter_ready <= 1'b1;
        end else if (abort) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            letter_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level        <= level_next;
            letter_ready <= (level_next != FULL_LEVEL);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:  if (start && level != '0) state_next = LOAD;
            LOAD:  state_next = SHIFT;
            SHIFT: if (tick && unit_cnt == LAST_SHIFT_UNIT) state_next = GAP;
            GAP: begin
                // The queue is only consulted at the end of the normal 3-unit gap.
                if (tick && unit_cnt == LETTER_GAP_UNIT) begin
                    if (level != '0)
                        state_next = LOAD;
                    else
`ifdef MORSE_WORD_GAP_EN
                        state_next = GAP;
`else
                        state_next = DONE;
`endif
                end
`ifdef MORSE_WORD_GAP_EN
                else if (tick && unit_cnt == WORD_GAP_UNIT)
                    state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led      <= 1'b0;
            pattern  <= '0;
            unit_cnt <= '0;
            tick_cnt <= '0;
        end else if (abort) begin
            led      <= 1'b0;
            pattern  <= '0;
            unit_cnt <= '0;
            tick_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    pattern  <= pattern_of(mem[rd_ptr]);
                    unit_cnt <= '0;
                    led      <= 1'b0;
                    tick_cnt <= TICK_RELOAD;
                end
                SHIFT, GAP: begin
                    if (tick) begin
                        tick_cnt <= TICK_RELOAD;
                        unit_cnt <= unit_cnt + 5'd1;
                        if (state == SHIFT) begin
                            led     <= pattern[13];
                            pattern <= {pattern[12:0], 1'b0};
                        end else begin
                            led <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - TW'(1);
                    end
                end
                default: begin
                    led      <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_message_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_message_player
// Purpose  : Self-checking bench; a cycle-offset model of the Morse player is
//            compared with the DUT every cycle, plus directed literal checks.
// Revision : 1.0
// ============================================================================
module tb_morse_message_player;
    localparam int T     = 4;
    localparam int DEPTH = 4;
`ifdef MORSE_WORD_GAP_EN
    localparam int LAST_END = 20 * T;
`else
    localparam int LAST_END = 16 * T;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       letter_valid = 1'b0;
    logic [2:0] letter = 3'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       letter_ready;
    logic       led;
    logic       busy;
    logic       done;
    logic [2:0] level;

    morse_message_player #(.TICK_DIV(T), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .letter_valid(letter_valid),
        .letter(letter), .letter_ready(letter_ready), .start(start),
        .abort(abort), .led(led), .busy(busy), .done(done), .level(level)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] pat_of(input logic [2:0] code);
        case (code)
            3'd0:    return 14'b10101000000000;
            3'd1:    return 14'b11100000000000;
            3'd2:    return 14'b10101110000000;
            3'd3:    return 14'b10101011100000;
            3'd4:    return 14'b10111011100000;
            3'd5:    return 14'b11101010111000;
            3'd6:    return 14'b11101011101110;
            default: return 14'b11101110101000;
        endcase
    endfunction

    // Model: m_rel counts cycles since the letter's LOAD cycle.
    typedef enum {M_IDLE, M_PLAY, M_DONE} mmode_t;
    mmode_t     m_mode = M_IDLE;
    int         m_rel = 0;
    logic [13:0] m_pat = '0;
    logic [2:0] m_q[$];
    int         m_sz;
    bit         m_push;

    function automatic int exp_led();
        int k;
        if (m_mode != M_PLAY || m_rel < T + 1 || m_rel > 15 * T)
            return 0;
        k = (m_rel - 1) / T - 1;
        return int'(m_pat[13 - k]);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_mode = M_IDLE;
            m_rel  = 0;
            m_pat  = '0;
        end else if (abort) begin
            m_q.delete();
            m_mode = M_IDLE;
        end else begin
            m_sz   = m_q.size();
            m_push = letter_valid && (m_sz < DEPTH);
            case (m_mode)
                M_IDLE: if (start && m_sz != 0) begin
                    m_mode = M_PLAY;
                    m_rel  = 0;
                end
                M_PLAY: begin
                    if (m_rel == 0)
                        m_pat = pat_of(m_q.pop_front());
                    if (m_rel == 16 * T && m_sz != 0)
                        m_rel = 0;
                    else if (m_rel == LAST_END)
                        m_mode = M_DONE;
                    else
                        m_rel++;
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_push)
                m_q.push_back(letter);
        end
    end

    int led_high = 0;
    int done_cnt = 0;
    int last_done = -1;
    int busy_after_done = -1;
    bit prev_done = 0;

    always @(negedge clock) begin
        check("led", int'(led), exp_led());
        check("busy", int'(busy), int'(m_mode != M_IDLE));
        check("done", int'(done), int'(m_mode == M_DONE));
        check("letter_ready", int'(letter_ready), int'(m_q.size() < DEPTH));
        check("level", int'(level), m_q.size());
        if (prev_done) busy_after_done = int'(busy);
        prev_done = done;
        if (led) led_high++;
        if (done) begin
            done_cnt++;
            last_done = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push_one(input logic [2:0] code);
        letter_valid = 1'b1;
        letter       = code;
        step(1);
        letter_valid = 1'b0;
    endtask

    // Pulses start; returns the cycle index of the LOAD cycle.
    task automatic kick(output int load);
        start = 1'b1;
        load  = cyc + 1;
        led_high = 0;
        done_cnt = 0;
        busy_after_done = -1;
        step(1);
        start = 1'b0;
    endtask

    int load;

    initial begin
        step(3);
        reset_n = 1'b1;
        step(1);
        check("reset level", int'(level), 0);
        check("reset ready", int'(letter_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset led", int'(led), 0);

        // Single T: 12 lit cycles, done 1+16T after LOAD, idle right after.
        push_one(3'd1);
        kick(load);
        step(LAST_END + 10);
        check("T lit cycles", led_high, 12);
        check("T done count", done_cnt, 1);
        check("T done offset", last_done - load, LAST_END + 1);
        check("T busy after done", busy_after_done, 0);

        // S then Z back-to-back.
        push_one(3'd0);
        push_one(3'd7);
        kick(load);
        step(16 * T + LAST_END + 10);
        check("SZ lit cycles", led_high, 44);
        check("SZ done count", done_cnt, 1);
        check("SZ done offset", last_done - load, 16 * T + LAST_END + 2);

        // Five pushes with valid held into a depth-4 queue.
        letter_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            letter = 3'(i);
            step(1);
        end
        letter_valid = 1'b0;
        check("full level", int'(level), 4);
        check("full ready", int'(letter_ready), 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("flush level", int'(level), 0);
        check("flush ready", int'(letter_ready), 1);

        // U pushed during T's SHIFT plays without a new start.
        push_one(3'd1);
        kick(load);
        step(10);
        push_one(3'd2);
        step(16 * T + LAST_END + 10);
        check("TU lit cycles", led_high, 32);
        check("TU done count", done_cnt, 1);
        check("TU done offset", last_done - load, 16 * T + LAST_END + 2);

        // Abort mid-SHIFT with two letters still queued.
        push_one(3'd6);
        push_one(3'd5);
        push_one(3'd4);
        kick(load);
        step(8);
        check("pre-abort level", int'(level), 2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort led", int'(led), 0);
        check("abort level", int'(level), 0);
        check("abort busy", int'(busy), 0);
        step(100);
        check("abort no done", done_cnt, 0);

        // Asynchronous reset while Z's first dash is lit.
        push_one(3'd7);
        kick(load);
        step(T + 2);
        check("Z lit before reset", int'(led), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async reset led", int'(led), 0);
        step(2);
        reset_n = 1'b1;
        step(2);

        // Random traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            letter_valid = ($urandom_range(0, 3) == 0);
            letter       = 3'($urandom_range(0, 7));
            start        = ($urandom_range(0, 15) == 0);
            abort        = ($urandom_range(0, 499) == 0);
            step(1);
        end
        letter_valid = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        step(DEPTH * 16 * T + LAST_END + 20);
        check("drain busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
